status_flag_unit: RTL and testbench
===================================

# status_flag_unit

Producer side of the NZCV status register. Computes N/Z/C/V from the EXE-stage ALU operands and result, holds them in a one-entry pending stage, and commits them to the architectural status register one cycle later unless killed. Drives the 32-bit status word that the ID-stage condition checker consumes, and asserts a stall request when a consumer would otherwise read stale flags.

## Interface
Parameters:
- `WIDTH`, 32, ALU datapath width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `exe_valid`  in  1  a valid instruction is in EXE this cycle.
- `exe_s`  in  1  the instruction's S bit (update flags).
- `exe_cmd`  in  4  ALU command: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; any other value is a no-flag op.
- `op_a`  in  WIDTH  ALU operand 1.
- `op_b`  in  WIDTH  ALU operand 2, after the shifter.
- `shift_c`  in  1  shifter carry-out.
- `alu_res`  in  WIDTH+1  ALU result; bit WIDTH is the adder carry-out.
- `stall`  in  1  pipeline freeze; no state advances.
- `kill`  in  1  flush the instruction in the pending stage (branch taken).
- `cond_use`  in  1  ID-stage instruction depends on flags (cond ≠ 1110).
- `status_reg_out`  out  32  bits [31:28] = N,Z,C,V; bits [27:0] = 0.
- `flags_stall`  out  1  flags hazard; ID must hold.

## Operation
- Flag generation, combinational from EXE inputs: N = `alu_res[WIDTH-1]`; Z = (`alu_res[WIDTH-1:0]` == 0).
- ADD/ADC: C = `alu_res[WIDTH]`; V = (a_msb == b_msb) && (r_msb != a_msb).
- SUB/SBC: C = `alu_res[WIDTH]`, taken from the adder as not-borrow; V = (a_msb != b_msb) && (r_msb != a_msb).
- MOV/MVN/AND/ORR/EOR: C = `shift_c`; V = old V.
- No-flag op with `exe_s` = 1: nothing is captured.
- Capture: if `exe_valid && exe_s && !stall` and the op is a flag op, then on the edge `pend_valid` ← 1 and `pend_flags` ← new NZCV. Otherwise `pend_valid` ← 0 when `!stall`.
- Commit: if `pend_valid && !stall && !kill`, then `arch_flags` ← `pend_flags` on the same edge that the pending stage advances.
- `kill` with `pend_valid` set: the pending entry is dropped and `arch_flags` is unchanged. A new capture on that edge is also suppressed, because EXE is flushed too.
- `stall` freezes `pend_valid`, `pend_flags` and `arch_flags`; `kill` during `stall` takes effect only when `stall` deasserts.
- Old V for MOV/logic ops is taken from `pend_flags` if `pend_valid`, else from `arch_flags`. This keeps back-to-back flag ops correct.
- Hazard: `flags_stall` = `cond_use && (capture_this_cycle || pend_valid)`. This applies when `STATUS_FLAG_FWD_EN` is absent; see Configuration.

## Timing
- Reset (`rst_n` = 0 at an edge): `arch_flags` = 0000, `pend_valid` = 0, `pend_flags` = 0000, `status_reg_out` = 0, `flags_stall` = 0.
- Reset has priority over `stall` and `kill`. Reset in the middle of an update discards any pending flags.
- Latency, no forwarding: a flag op in EXE at cycle t gives `status_reg_out` updated in cycle t+2.
- `flags_stall` is combinational, valid within the same cycle.
- Two consecutive flag ops: the second overwrites `pend_flags` while the first commits. The final value equals the second op's flags.

## Configuration
- `STATUS_FLAG_FWD_EN` defined:
  - `status_reg_out[31:28]` = the newest value in priority order: flags being captured this cycle, else `pend_flags` if `pend_valid`, else `arch_flags`.
  - A killed pending entry is never forwarded; `kill` masks the pending source.
  - `flags_stall` is tied to 0.
  - Flag op at t is visible to the ID consumer at t (0 extra cycles).
- `STATUS_FLAG_FWD_EN` not defined:
  - `status_reg_out` shows `arch_flags` only.
  - Hazard stall as described under Operation.

## Structure
- Shared package holds:
  - the ALU command constants (`EXE_MOV` … `EXE_EOR`);
  - NZCV bit positions (`FLAG_N` = 31 … `FLAG_V` = 28);
  - the `nzcv_t` 4-bit typedef.
- One sub-module, `nzcv_calc`: combinational flag generation from cmd/operands/result/old_v. The top-level holds the registers, kill/stall logic and forwarding mux.

## Test plan
- ADD 0x7FFFFFFF + 1, S = 1 → after commit, `status_reg_out` = 0x90000000 (N = 1, V = 1).
- SUB 5 − 5, S = 1 → 0x60000000 (Z = 1, C = 1). SUB 3 − 5 → 0x80000000 (N = 1, C = 0).
- ADD with S = 0, then AND 0 with `shift_c` = 1 and prior V = 1 → flags unchanged after the ADD, then 0x70000000.
- Flag op followed by `kill` in the pending cycle → `arch_flags` keeps its prior value (e.g. 0x20000000).
- Flag op with `cond_use` = 1 in the same and the next cycle:
  - without `STATUS_FLAG_FWD_EN`: `flags_stall` = 1 for 2 cycles;
  - with it: `flags_stall` = 0 and the new flags are visible immediately.
- `stall` held 3 cycles with a pending entry, then `rst_n` = 0 → entry frozen during the stall, then all outputs 0 after the reset edge.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_flag_unit_pkg
// Description : Shared ALU command codes, NZCV bit positions and flag type
//               for the status flag producer.
// Revision    : 1.0  initial release
// ============================================================================
package status_flag_unit_pkg;

    // ALU command encodings seen on exe_cmd
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Flag positions inside the 32-bit status word
    localparam int FLAG_N = 31;
    localparam int FLAG_Z = 30;
    localparam int FLAG_C = 29;
    localparam int FLAG_V = 28;

    // Flag positions inside a packed nzcv_t value
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // {N, Z, C, V}
    typedef logic [3:0] nzcv_t;

    // Place a flag nibble into its slot of the status word
    function automatic logic [31:0] pack_status(input nzcv_t f);
        logic [31:0] w;
        w = '0;
        w[FLAG_N:FLAG_V] = f;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_flag_unit_nzcv_calc.sv
`default_nettype none
// ============================================================================
// Module      : nzcv_calc
// Description : Combinational NZCV generation from the EXE-stage ALU command,
//               operand sign bits, ALU result and the previous V flag.
// Revision    : 1.0  initial release
// ============================================================================
module nzcv_calc
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]     i_cmd,
    input  logic           i_a_msb,
    input  logic           i_b_msb,
    input  logic [WIDTH:0] i_res,
    input  logic           i_shift_c,
    input  logic           i_old_v,
    output logic           o_flag_op,
    output nzcv_t          o_flags
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    // Decode the command and derive N/Z/C/V; non-arithmetic ops keep V
    always_comb begin
        w_n       = i_res[WIDTH-1];
        w_z       = (i_res[WIDTH-1:0] == '0);
        w_c       = i_shift_c;
        w_v       = i_old_v;
        o_flag_op = 1'b0;
        case (i_cmd)
            EXE_ADD, EXE_ADC: begin
                o_flag_op = 1'b1;
                w_c       = i_res[WIDTH];
                w_v       = (i_a_msb == i_b_msb) && (w_n != i_a_msb);
            end
            EXE_SUB, EXE_SBC: begin
                // Adder carry-out is the not-borrow for subtraction
                o_flag_op = 1'b1;
                w_c       = i_res[WIDTH];
                w_v       = (i_a_msb != i_b_msb) && (w_n != i_a_msb);
            end
            EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR: begin
                o_flag_op = 1'b1;
            end
            default: begin
                o_flag_op = 1'b0;
            end
        endcase
        o_flags = {w_n, w_z, w_c, w_v};
    end

endmodule
`default_nettype wire

// File: rtl/status_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : status_flag_unit
// Description : NZCV producer. Captures flags from EXE into a one-entry
//               pending stage, commits them to the architectural flags one
//               cycle later unless killed, and raises a hazard stall for
//               flag-dependent ID instructions.
//               Optional macro STATUS_FLAG_FWD_EN: forward the newest flags
//               to status_reg_out and tie flags_stall low.
// Revision    : 1.0  initial release
// ============================================================================
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exe_valid,
    input  logic             exe_s,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             shift_c,
    input  logic [WIDTH:0]   alu_res,
    input  logic             stall,
    input  logic             kill,
    input  logic             cond_use,
    output logic [31:0]      status_reg_out,
    output logic             flags_stall
);

    nzcv_t r_arch_flags;
    nzcv_t r_pend_flags;
    logic  r_pend_valid;

    nzcv_t w_new_flags;
    logic  w_flag_op;
    logic  w_old_v;
    logic  w_capture;
    nzcv_t w_out_flags;

    // Only operand sign bits matter for overflow; the rest is intentionally dropped
    logic  w_unused_ok;

    // The pending entry is newer than the architectural flags, so its V wins
    assign w_old_v = r_pend_valid ? r_pend_flags[NZCV_V] : r_arch_flags[NZCV_V];

    nzcv_calc #(
        .WIDTH (WIDTH)
    ) u_nzcv_calc (
        .i_cmd     (exe_cmd),
        .i_a_msb   (op_a[WIDTH-1]),
        .i_b_msb   (op_b[WIDTH-1]),
        .i_res     (alu_res),
        .i_shift_c (shift_c),
        .i_old_v   (w_old_v),
        .o_flag_op (w_flag_op),
        .o_flags   (w_new_flags)
    );

    // A kill flushes EXE as well, so it also blocks a capture on that edge
    assign w_capture = exe_valid && exe_s && w_flag_op && !stall && !kill;

    // Pending stage and architectural flags; reset beats stall and kill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arch_flags <= '0;
            r_pend_flags <= '0;
            r_pend_valid <= 1'b0;
        end else if (!stall) begin
            if (r_pend_valid && !kill) begin
                r_arch_flags <= r_pend_flags;
            end
            r_pend_valid <= w_capture;
            if (w_capture) begin
                r_pend_flags <= w_new_flags;
            end
        end
    end

`ifdef STATUS_FLAG_FWD_EN
    // Newest flags win: this cycle's capture, then a live pending entry, then arch
    always_comb begin
        if (w_capture) begin
            w_out_flags = w_new_flags;
        end else if (r_pend_valid && !kill) begin
            w_out_flags = r_pend_flags;
        end else begin
            w_out_flags = r_arch_flags;
        end
    end

    assign flags_stall = 1'b0;
    assign w_unused_ok = ^{op_a[WIDTH-2:0], op_b[WIDTH-2:0], cond_use};
`else
    // Consumers only ever see committed flags
    always_comb begin
        w_out_flags = r_arch_flags;
    end

    assign flags_stall = cond_use && (w_capture || r_pend_valid);
    assign w_unused_ok = ^{op_a[WIDTH-2:0], op_b[WIDTH-2:0]};
`endif

    assign status_reg_out = pack_status(w_out_flags);

endmodule
`default_nettype wire

// File: tb/tb_status_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_flag_unit
// Description : Self-checking bench for status_flag_unit: directed scenarios
//               with literal expectations followed by randomized traffic
//               compared every cycle against a behavioural flag model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_status_flag_unit;

`ifdef STATUS_FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_valid;
    logic        exe_s;
    logic [3:0]  exe_cmd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        shift_c;
    logic [32:0] alu_res;
    logic        stall;
    logic        kill;
    logic        cond_use;
    logic [31:0] status_reg_out;
    logic        flags_stall;

    logic        tb_cin;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Model state: committed flags and the one-entry pending slot
    logic [3:0]  m_arch;
    logic [3:0]  m_pend;
    logic        m_pend_v;
    bit          m_ok = 1'b0;

    status_flag_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exe_valid      (exe_valid),
        .exe_s          (exe_s),
        .exe_cmd        (exe_cmd),
        .op_a           (op_a),
        .op_b           (op_b),
        .shift_c        (shift_c),
        .alu_res        (alu_res),
        .stall          (stall),
        .kill           (kill),
        .cond_use       (cond_use),
        .status_reg_out (status_reg_out),
        .flags_stall    (flags_stall)
    );

    always #5 clk = ~clk;

    function automatic bit is_flag_cmd(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd9);
    endfunction

    // The ALU that feeds the DUT
    function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
        case (c)
            4'd1:    return {1'b0, b};
            4'd9:    return {1'b0, ~b};
            4'd2:    return {1'b0, a} + {1'b0, b};
            4'd3:    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
            4'd4:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'd5:    return {1'b0, a} + {1'b0, ~b} + {32'd0, ci};
            4'd6:    return {1'b0, a & b};
            4'd7:    return {1'b0, a | b};
            4'd8:    return {1'b0, a ^ b};
            default: return {$urandom_range(0, 1) == 1, $urandom()};
        endcase
    endfunction

    // Flags from exact integer arithmetic: V = true result not representable
    function automatic logic [3:0] ref_flags(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [32:0] r,
                                             input logic shc, input logic ci, input logic oldv);
        longint sa, sb, ua, ub, ex, k;
        logic   n, z, cf, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        n  = r[31];
        z  = (r[31:0] == 32'd0);
        cf = shc;
        v  = oldv;
        if (c == 4'd2 || c == 4'd3) begin
            k  = (c == 4'd3) ? longint'(ci) : 0;
            ex = sa + sb + k;
            v  = (ex != longint'($signed(r[31:0])));
            cf = (ua + ub + k) > 64'sd4294967295;
        end else if (c == 4'd4 || c == 4'd5) begin
            k  = (c == 4'd5) ? longint'(!ci) : 0;
            ex = sa - sb - k;
            v  = (ex != longint'($signed(r[31:0])));
            cf = (ua >= ub + k);
        end
        return {n, z, cf, v};
    endfunction

    function automatic logic [3:0] model_new();
        return ref_flags(exe_cmd, op_a, op_b, alu_res, shift_c, tb_cin,
                         m_pend_v ? m_pend[0] : m_arch[0]);
    endfunction

    function automatic bit model_cap();
        return exe_valid && exe_s && is_flag_cmd(exe_cmd) && !stall && !kill;
    endfunction

    // Model advance on each rising edge
    always @(posedge clk) begin
        logic [3:0] nf;
        bit         cap;
        if (!rst_n) begin
            m_arch   = 4'd0;
            m_pend   = 4'd0;
            m_pend_v = 1'b0;
            m_ok     = 1'b1;
        end else if (m_ok && !stall) begin
            nf  = model_new();
            cap = model_cap();
            if (m_pend_v && !kill) m_arch = m_pend;
            m_pend_v = cap;
            if (cap) m_pend = nf;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [3:0] ef;
        logic       es;
        if (m_ok) begin
            if (FWD) begin
                if (model_cap())              ef = model_new();
                else if (m_pend_v && !kill)   ef = m_pend;
                else                          ef = m_arch;
                es = 1'b0;
            end else begin
                ef = m_arch;
                es = cond_use && (model_cap() || m_pend_v);
            end
            n_checks++;
            if (status_reg_out !== {ef, 28'd0}) begin
                n_fail++;
                $display("FAIL model_status t=%0t got %h expected %h", $time, status_reg_out, {ef, 28'd0});
            end
            n_checks++;
            if (flags_stall !== es) begin
                n_fail++;
                $display("FAIL model_stall t=%0t got %b expected %b", $time, flags_stall, es);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 1'b0;
        exe_s     = 1'b0;
        exe_cmd   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        shift_c   = 1'b0;
        alu_res   = 33'd0;
        stall     = 1'b0;
        kill      = 1'b0;
        cond_use  = 1'b0;
        tb_cin    = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic shc, input logic ci);
        exe_valid = 1'b1;
        exe_s     = s;
        exe_cmd   = c;
        op_a      = a;
        op_b      = b;
        shift_c   = shc;
        tb_cin    = ci;
        alu_res   = alu_fn(c, a, b, ci);
    endtask

    // Directed flag op: issue, one pending cycle, then check committed value
    task automatic op_commit(input string name, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic shc, input logic [31:0] exp);
        cyc(); set_op(c, a, b, 1'b1, shc, 1'b1);
        cyc(); idle();
        cyc();
        @(negedge clk); chk(name, status_reg_out, exp);
    endtask

    initial begin
        logic [31:0] specials [5];
        specials = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        rst_n = 1'b0;
        idle();
        repeat (2) cyc();
        @(negedge clk);
        chk("reset_status", status_reg_out, 32'h0);
        chk("reset_stall", {31'd0, flags_stall}, 32'h0);
        cyc(); rst_n = 1'b1;

        op_commit("add_overflow", 4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h9000_0000);

        // ADD without S, then AND giving zero with shifter carry and prior V
        cyc(); set_op(4'd2, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        cyc(); set_op(4'd6, 32'd0, 32'hFFFF, 1'b1, 1'b1, 1'b0);
        cyc(); idle();
        @(negedge clk); chk("add_no_s", status_reg_out, FWD ? 32'h7000_0000 : 32'h9000_0000);
        cyc();
        @(negedge clk); chk("and_zero", status_reg_out, 32'h7000_0000);

        op_commit("sub_equal", 4'd4, 32'd5, 32'd5, 1'b0, 32'h6000_0000);
        op_commit("sub_negative", 4'd4, 32'd3, 32'd5, 1'b0, 32'h8000_0000);
        op_commit("mov_carry", 4'd1, 32'd0, 32'd1, 1'b1, 32'h2000_0000);

        // Kill in the pending cycle keeps the prior flags
        cyc(); set_op(4'd4, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1);
        cyc(); idle(); kill = 1'b1;
        @(negedge clk); chk("kill_pending", status_reg_out, 32'h2000_0000);
        cyc(); kill = 1'b0;
        @(negedge clk); chk("kill_keep", status_reg_out, 32'h2000_0000);

        // Hazard: consumer in the capture cycle and in the pending cycle
        cyc(); set_op(4'd2, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0); cond_use = 1'b1;
        @(negedge clk);
        chk("hazard_capture", {31'd0, flags_stall}, FWD ? 32'd0 : 32'd1);
        if (FWD) chk("fwd_visible", status_reg_out, 32'h0);
        cyc(); idle(); cond_use = 1'b1;
        @(negedge clk); chk("hazard_pending", {31'd0, flags_stall}, FWD ? 32'd0 : 32'd1);
        cyc(); cond_use = 1'b1;
        @(negedge clk); chk("hazard_clear", {31'd0, flags_stall}, 32'd0);
        chk("add_small", status_reg_out, 32'h0);

        // Stall freezes a pending entry; reset then clears everything
        cyc(); set_op(4'd4, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); stall = 1'b1;
            @(negedge clk); chk("stall_frozen", status_reg_out, FWD ? 32'h6000_0000 : 32'h0);
        end
        cyc(); stall = 1'b1; rst_n = 1'b0;
        cyc(); idle(); rst_n = 1'b1;
        @(negedge clk); chk("reset_after_stall", status_reg_out, 32'h0);
        chk("reset_after_stall_hz", {31'd0, flags_stall}, 32'd0);
        cyc();
        @(negedge clk); chk("reset_discard", status_reg_out, 32'h0);

        // Randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            cyc();
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            set_op(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exe_valid = ($urandom_range(0, 4) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            kill      = m_pend_v && ($urandom_range(0, 5) == 0);
            cond_use  = 1'($urandom_range(0, 1));
            rst_n     = ($urandom_range(0, 59) != 0);
        end
        cyc(); idle(); rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
